// File: rtl/img_pkg.sv
// Types shared by the 3x3 window generator and the image processor port it feeds.
package img_pkg;

    localparam int PIX_W_DEF = 8;

    typedef logic [7:0] pixel_t;
    typedef pixel_t [0:2][0:2] window_t;

    typedef enum logic {
        FILL = 1'b0,
        RUN  = 1'b1
    } wg_state_t;

endpackage

// File: rtl/window_gen_3x3_line_buffer.sv
// One image row of delay: dout is the value written DEPTH enables ago (read-before-write).
module line_buffer #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_LAST = AW'(DEPTH - 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_ptr;

    assign dout = r_mem[r_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (en) begin
            r_ptr <= (r_ptr == PTR_LAST) ? '0 : r_ptr + AW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (en) begin
            r_mem[r_ptr] <= din;
        end
    end

endmodule

// File: rtl/window_gen_3x3.sv
// Raster pixel stream to 3x3 neighbourhood stream; no edge padding, one-entry output register.
module window_gen_3x3
    import img_pkg::*;
#(
    parameter int IMG_WIDTH  = 8,
    parameter int IMG_HEIGHT = 8,
    parameter int PIX_W      = PIX_W_DEF
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [PIX_W-1:0]            pixel_in,
    input  logic                        pixel_sof,
    input  logic                        pixel_valid,
    output logic                        pixel_ready,
    output logic [0:2][0:2][PIX_W-1:0]  window,
    output logic                        window_valid,
    input  logic                        window_ready,
    output logic                        window_last
);

    localparam int CW = $clog2(IMG_WIDTH);
    localparam int RW = $clog2(IMG_HEIGHT);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);

    logic [CW-1:0]                 r_col;
    logic [RW-1:0]                 r_row;
    wg_state_t                     r_state;
    wg_state_t                     w_state_nxt;
    logic                          w_accept;
    logic                          w_load;
    logic                          w_last_px;
    logic [PIX_W-1:0]              w_lb0_dout;
    logic [PIX_W-1:0]              w_lb1_dout;
    logic [0:2][PIX_W-1:0]         w_taps;
    logic [0:2][0:1][PIX_W-1:0]    r_hist;
    logic [0:2][0:2][PIX_W-1:0]    w_win_nxt;

    assign pixel_ready = !window_valid || window_ready;
    assign w_accept    = pixel_valid && pixel_ready;

    line_buffer #(.DEPTH(IMG_WIDTH), .WIDTH(PIX_W)) u_lb0 (
        .clk  (clk),
        .rst  (rst),
        .en   (w_accept),
        .din  (pixel_in),
        .dout (w_lb0_dout)
    );

    line_buffer #(.DEPTH(IMG_WIDTH), .WIDTH(PIX_W)) u_lb1 (
        .clk  (clk),
        .rst  (rst),
        .en   (w_accept),
        .din  (w_lb0_dout),
        .dout (w_lb1_dout)
    );

    assign w_taps[0] = w_lb1_dout;
    assign w_taps[1] = w_lb0_dout;
    assign w_taps[2] = pixel_in;

    // Two registered columns per row; the live taps form the newest column.
    always_comb begin
        w_win_nxt = '0;
        for (int i = 0; i < 3; i++) begin
            w_win_nxt[i][0] = r_hist[i][0];
            w_win_nxt[i][1] = r_hist[i][1];
            w_win_nxt[i][2] = w_taps[i];
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept) begin
            for (int i = 0; i < 3; i++) begin
                r_hist[i][0] <= r_hist[i][1];
                r_hist[i][1] <= w_taps[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_col <= '0;
            r_row <= '0;
        end else if (w_accept) begin
            if (pixel_sof) begin
                r_col <= CW'(1);
                r_row <= '0;
            end else if (r_col == COL_LAST) begin
                r_col <= '0;
                r_row <= (r_row == ROW_LAST) ? '0 : r_row + RW'(1);
            end else begin
                r_col <= r_col + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= FILL;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // RUN is entered exactly when the row counter reaches 2, so it doubles as the row >= 2 gate.
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_last_px   = 1'b0;
        if (w_accept) begin
            if (pixel_sof) begin
                w_state_nxt = FILL;
            end else begin
                case (r_state)
                    FILL: begin
                        if (r_row == RW'(1) && r_col == COL_LAST) begin
                            w_state_nxt = RUN;
                        end
                    end
                    RUN: begin
                        if (r_col >= CW'(2)) begin
                            w_load    = 1'b1;
                            w_last_px = (r_row == ROW_LAST) && (r_col == COL_LAST);
                        end
                        if (r_row == ROW_LAST && r_col == COL_LAST) begin
                            w_state_nxt = FILL;
                        end
                    end
                    default: w_state_nxt = FILL;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            window       <= '0;
            window_valid <= 1'b0;
            window_last  <= 1'b0;
        end else if (w_load) begin
            window       <= w_win_nxt;
            window_valid <= 1'b1;
            window_last  <= w_last_px;
        end else if (window_ready) begin
            window_valid <= 1'b0;
            window_last  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_window_gen_3x3.sv
// Bench for window_gen_3x3 on a 5x4 frame against a frame-array reference model.
module tb_window_gen_3x3;

    localparam int W = 5;
    localparam int H = 4;

    typedef logic [0:2][0:2][7:0] win_t;

    logic       clk;
    logic       rst;
    logic [7:0] pixel_in;
    logic       pixel_sof;
    logic       pixel_valid;
    logic       pixel_ready;
    win_t       window;
    logic       window_valid;
    logic       window_ready;
    logic       window_last;

    window_gen_3x3 #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .PIX_W(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .pixel_in     (pixel_in),
        .pixel_sof    (pixel_sof),
        .pixel_valid  (pixel_valid),
        .pixel_ready  (pixel_ready),
        .window       (window),
        .window_valid (window_valid),
        .window_ready (window_ready),
        .window_last  (window_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   n_checks = 0;
    int   n_err    = 0;
    int   cyc      = 0;
    win_t cap_q[$];
    win_t exp_q[$];
    bit   cap_last[$];
    bit   exp_last[$];
    logic [7:0] fr [H][W];
    int   m_r = 0;
    int   m_c = 0;
    logic obs_pr, obs_wv, obs_last;
    win_t obs_win;

    function automatic win_t mkwin(input int base);
        win_t w;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                w[i][j] = 8'(base + W * i + j);
        return w;
    endfunction

    // Reference: place the pixel at its raster position; any position with row,col >= 2 yields a window.
    task automatic model_accept(input logic [7:0] pix, input bit sof);
        win_t w;
        if (sof) begin
            m_r = 0;
            m_c = 0;
        end
        fr[m_r][m_c] = pix;
        if (m_r >= 2 && m_c >= 2) begin
            for (int i = 0; i < 3; i++)
                for (int j = 0; j < 3; j++)
                    w[i][j] = fr[m_r - 2 + i][m_c - 2 + j];
            exp_q.push_back(w);
            exp_last.push_back(m_r == H - 1 && m_c == W - 1);
        end
        m_c++;
        if (m_c == W) begin
            m_c = 0;
            m_r++;
            if (m_r == H) m_r = 0;
        end
    endtask

    task automatic step(input bit v, input logic [7:0] pix, input bit sof, input bit wr,
                        input bit rs, output bit acc);
        pixel_valid  = v;
        pixel_in     = pix;
        pixel_sof    = sof;
        window_ready = wr;
        rst          = rs;
        @(negedge clk);
        obs_pr   = pixel_ready;
        obs_wv   = window_valid;
        obs_win  = window;
        obs_last = window_last;
        acc = v && pixel_ready && !rs;
        if (rs) begin
            m_r = 0;
            m_c = 0;
            exp_q.delete();
            exp_last.delete();
            cap_q.delete();
            cap_last.delete();
        end else begin
            if (window_valid && wr) begin
                cap_q.push_back(window);
                cap_last.push_back(window_last);
            end
            if (acc) model_accept(pix, sof);
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic push_pix(input logic [7:0] pix, input bit sof);
        bit acc = 1'b0;
        int tries = 0;
        while (!acc && tries < 50) begin
            step(1'b1, pix, sof, 1'b1, 1'b0, acc);
            tries++;
        end
        if (!acc) begin
            n_checks++;
            n_err++;
            $display("FAIL push_pix_timeout accepted 0 expected 1 (pixel %0d)", pix);
        end
    endtask

    task automatic drain(input int n);
        bit acc;
        repeat (n) step(1'b0, 8'd0, 1'b0, 1'b1, 1'b0, acc);
    endtask

    task automatic clear_q();
        cap_q.delete();
        cap_last.delete();
        exp_q.delete();
        exp_last.delete();
    endtask

    task automatic test_reset();
        bit acc;
        step(1'b0, 8'd0, 1'b0, 1'b0, 1'b1, acc);
        step(1'b0, 8'd0, 1'b0, 1'b0, 1'b1, acc);
        n_checks++; if (pixel_ready !== 1'b1) begin n_err++; $display("FAIL rst_pixel_ready got %b exp 1", pixel_ready); end
        n_checks++; if (window_valid !== 1'b0) begin n_err++; $display("FAIL rst_window_valid got %b exp 0", window_valid); end
        n_checks++; if (window_last !== 1'b0) begin n_err++; $display("FAIL rst_window_last got %b exp 0", window_last); end
        n_checks++; if (window !== '0) begin n_err++; $display("FAIL rst_window got %h exp 0", window); end
        step(1'b0, 8'd0, 1'b0, 1'b0, 1'b0, acc);
    endtask

    task automatic test_full_frame();
        int c0;
        clear_q();
        c0 = cyc;
        for (int k = 0; k < W * H; k++) begin
            push_pix(8'(k + 1), k == 0);
            if (k == 11) begin
                n_checks++; if (window_valid !== 1'b0) begin n_err++; $display("FAIL ff_early_valid got %b exp 0", window_valid); end
            end
            if (k == 12) begin
                n_checks++; if (window_valid !== 1'b1) begin n_err++; $display("FAIL ff_latency_valid got %b exp 1", window_valid); end
                n_checks++; if (window !== mkwin(1)) begin n_err++; $display("FAIL ff_first_win got %h exp %h", window, mkwin(1)); end
            end
        end
        n_checks++; if (cyc - c0 !== W * H) begin n_err++; $display("FAIL ff_throughput got %0d cycles exp %0d", cyc - c0, W * H); end
        drain(3);
        n_checks++; if (cap_q.size() !== 6) begin n_err++; $display("FAIL ff_count got %0d exp 6", cap_q.size()); end
        if (cap_q.size() == 6) begin
            n_checks++; if (cap_q[5] !== mkwin(8)) begin n_err++; $display("FAIL ff_last_win got %h exp %h", cap_q[5], mkwin(8)); end
            for (int i = 0; i < 6; i++) begin
                n_checks++;
                if (cap_last[i] !== (i == 5)) begin n_err++; $display("FAIL ff_last_flag[%0d] got %b exp %b", i, cap_last[i], i == 5); end
            end
        end
        n_checks++; if (cap_q.size() !== exp_q.size()) begin n_err++; $display("FAIL ff_model_count got %0d exp %0d", cap_q.size(), exp_q.size()); end
        for (int i = 0; i < cap_q.size() && i < exp_q.size(); i++) begin
            n_checks++;
            if (cap_q[i] !== exp_q[i] || cap_last[i] !== exp_last[i]) begin
                n_err++; $display("FAIL ff_model[%0d] got %h/%b exp %h/%b", i, cap_q[i], cap_last[i], exp_q[i], exp_last[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        bit acc;
        clear_q();
        for (int k = 0; k < 13; k++) push_pix(8'(k + 1), k == 0);
        for (int s = 0; s < 4; s++) begin
            step(1'b1, 8'd14, 1'b0, 1'b0, 1'b0, acc);
            n_checks++; if (obs_pr !== 1'b0) begin n_err++; $display("FAIL bp_pixel_ready[%0d] got %b exp 0", s, obs_pr); end
            n_checks++; if (obs_wv !== 1'b1) begin n_err++; $display("FAIL bp_valid[%0d] got %b exp 1", s, obs_wv); end
            n_checks++; if (obs_win !== mkwin(1)) begin n_err++; $display("FAIL bp_hold[%0d] got %h exp %h", s, obs_win, mkwin(1)); end
        end
        acc = 1'b0;
        for (int t = 0; t < 10 && !acc; t++) step(1'b1, 8'd14, 1'b0, 1'b1, 1'b0, acc);
        n_checks++; if (acc !== 1'b1) begin n_err++; $display("FAIL bp_release_accept got %b exp 1", acc); end
        for (int k = 14; k < W * H; k++) push_pix(8'(k + 1), 1'b0);
        drain(3);
        n_checks++; if (cap_q.size() !== 6) begin n_err++; $display("FAIL bp_count got %0d exp 6", cap_q.size()); end
        if (cap_q.size() >= 2) begin
            n_checks++; if (cap_q[1] !== mkwin(2)) begin n_err++; $display("FAIL bp_next_win got %h exp %h", cap_q[1], mkwin(2)); end
        end
        n_checks++; if (cap_q.size() !== exp_q.size()) begin n_err++; $display("FAIL bp_model_count got %0d exp %0d", cap_q.size(), exp_q.size()); end
        for (int i = 0; i < cap_q.size() && i < exp_q.size(); i++) begin
            n_checks++;
            if (cap_q[i] !== exp_q[i] || cap_last[i] !== exp_last[i]) begin
                n_err++; $display("FAIL bp_model[%0d] got %h/%b exp %h/%b", i, cap_q[i], cap_last[i], exp_q[i], exp_last[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        clear_q();
        for (int f = 0; f < 2; f++)
            for (int k = 0; k < W * H; k++) push_pix(8'(k + 1), f == 0 && k == 0);
        drain(3);
        n_checks++; if (cap_q.size() !== 12) begin n_err++; $display("FAIL b2b_count got %0d exp 12", cap_q.size()); end
        if (cap_q.size() == 12) begin
            n_checks++; if (cap_q[6] !== mkwin(1)) begin n_err++; $display("FAIL b2b_second_first got %h exp %h", cap_q[6], mkwin(1)); end
            n_checks++; if (cap_last[5] !== 1'b1 || cap_last[11] !== 1'b1) begin
                n_err++; $display("FAIL b2b_last_flags got %b%b exp 11", cap_last[5], cap_last[11]);
            end
        end
        n_checks++; if (cap_q.size() !== exp_q.size()) begin n_err++; $display("FAIL b2b_model_count got %0d exp %0d", cap_q.size(), exp_q.size()); end
        for (int i = 0; i < cap_q.size() && i < exp_q.size(); i++) begin
            n_checks++;
            if (cap_q[i] !== exp_q[i] || cap_last[i] !== exp_last[i]) begin
                n_err++; $display("FAIL b2b_model[%0d] got %h/%b exp %h/%b", i, cap_q[i], cap_last[i], exp_q[i], exp_last[i]);
            end
        end
    endtask

    task automatic test_sof_restart();
        clear_q();
        for (int k = 0; k < 7; k++) push_pix(8'(100 + k), 1'b0);
        for (int k = 0; k < W * H; k++) begin
            push_pix(8'(k + 1), k == 0);
            if (k < 12) begin
                n_checks++; if (window_valid !== 1'b0) begin n_err++; $display("FAIL sof_early_valid[%0d] got %b exp 0", k, window_valid); end
            end
            if (k == 12) begin
                n_checks++; if (window_valid !== 1'b1 || window !== mkwin(1)) begin
                    n_err++; $display("FAIL sof_first_win got %b/%h exp 1/%h", window_valid, window, mkwin(1));
                end
            end
        end
        drain(3);
        n_checks++; if (cap_q.size() !== 6) begin n_err++; $display("FAIL sof_count got %0d exp 6", cap_q.size()); end
        n_checks++; if (cap_q.size() !== exp_q.size()) begin n_err++; $display("FAIL sof_model_count got %0d exp %0d", cap_q.size(), exp_q.size()); end
        for (int i = 0; i < cap_q.size() && i < exp_q.size(); i++) begin
            n_checks++;
            if (cap_q[i] !== exp_q[i] || cap_last[i] !== exp_last[i]) begin
                n_err++; $display("FAIL sof_model[%0d] got %h/%b exp %h/%b", i, cap_q[i], cap_last[i], exp_q[i], exp_last[i]);
            end
        end
    endtask

    task automatic test_reset_midframe();
        bit acc;
        clear_q();
        for (int k = 0; k < 14; k++) push_pix(8'(k + 1), k == 0);
        n_checks++; if (cap_q.size() !== 1 || window_valid !== 1'b1) begin
            n_err++; $display("FAIL mrst_pre got %0d/%b exp 1/1", cap_q.size(), window_valid);
        end
        step(1'b0, 8'd0, 1'b0, 1'b0, 1'b1, acc);
        n_checks++; if (window_valid !== 1'b0) begin n_err++; $display("FAIL mrst_valid got %b exp 0", window_valid); end
        n_checks++; if (pixel_ready !== 1'b1) begin n_err++; $display("FAIL mrst_pixel_ready got %b exp 1", pixel_ready); end
        n_checks++; if (window !== '0 || window_last !== 1'b0) begin
            n_err++; $display("FAIL mrst_window got %h/%b exp 0/0", window, window_last);
        end
        for (int k = 0; k < W * H; k++) push_pix(8'(k + 1), 1'b0);
        drain(3);
        n_checks++; if (cap_q.size() !== 6) begin n_err++; $display("FAIL mrst_count got %0d exp 6", cap_q.size()); end
        if (cap_q.size() == 6) begin
            n_checks++; if (cap_q[0] !== mkwin(1) || cap_q[5] !== mkwin(8)) begin
                n_err++; $display("FAIL mrst_wins got %h,%h exp %h,%h", cap_q[0], cap_q[5], mkwin(1), mkwin(8));
            end
        end
        n_checks++; if (cap_q.size() !== exp_q.size()) begin n_err++; $display("FAIL mrst_model_count got %0d exp %0d", cap_q.size(), exp_q.size()); end
        for (int i = 0; i < cap_q.size() && i < exp_q.size(); i++) begin
            n_checks++;
            if (cap_q[i] !== exp_q[i] || cap_last[i] !== exp_last[i]) begin
                n_err++; $display("FAIL mrst_model[%0d] got %h/%b exp %h/%b", i, cap_q[i], cap_last[i], exp_q[i], exp_last[i]);
            end
        end
    endtask

    task automatic test_random();
        bit         acc;
        bit         v, wr, sof;
        int         k = 0;
        int         f = 0;
        int         budget = 0;
        logic [7:0] pix;
        void'($urandom(32'd2024));
        clear_q();
        pix = 8'($urandom_range(0, 255));
        sof = 1'b1;
        while (f < 10 && budget < 20000) begin
            v  = ($urandom_range(0, 9) < 7);
            wr = ($urandom_range(0, 9) < 6);
            step(v, pix, (k == 0) && sof, wr, 1'b0, acc);
            budget++;
            if (acc) begin
                pix = 8'($urandom_range(0, 255));
                k++;
                if (k == W * H) begin
                    k = 0;
                    f++;
                    sof = $urandom_range(0, 1) == 1;
                end
            end
        end
        n_checks++; if (f !== 10) begin n_err++; $display("FAIL rnd_timeout frames %0d exp 10", f); end
        drain(4);
        n_checks++; if (cap_q.size() !== 60) begin n_err++; $display("FAIL rnd_count got %0d exp 60", cap_q.size()); end
        n_checks++; if (cap_q.size() !== exp_q.size()) begin n_err++; $display("FAIL rnd_model_count got %0d exp %0d", cap_q.size(), exp_q.size()); end
        for (int i = 0; i < cap_q.size() && i < exp_q.size(); i++) begin
            n_checks++;
            if (cap_q[i] !== exp_q[i] || cap_last[i] !== exp_last[i]) begin
                n_err++; $display("FAIL rnd_model[%0d] got %h/%b exp %h/%b", i, cap_q[i], cap_last[i], exp_q[i], exp_last[i]);
            end
        end
    endtask

    initial begin
        rst          = 1'b1;
        pixel_in     = 8'd0;
        pixel_sof    = 1'b0;
        pixel_valid  = 1'b0;
        window_ready = 1'b0;
        test_reset();
        test_full_frame();
        test_backpressure();
        test_back_to_back();
        test_sof_restart();
        test_reset_midframe();
        test_random();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

endmodule
